// File: rtl/systolic_stream_driver_pkg.sv
// systolic_stream_driver_pkg: shared states, command codes, bank ids and packet field offsets
package systolic_stream_driver_pkg;
  typedef enum logic [1:0] {STATE_IDLE, STATE_LOAD, STATE_RUN, STATE_DRAIN} state_e;
  localparam logic [2:0] CMD_LOAD = 3'b100;
  localparam int CMD_LAST = 1;
  localparam logic [2:0] CMD_RUN = 3'b001;
  localparam logic [1:0] BANK_A_DIRECT = 2'd0;
  localparam logic [1:0] BANK_A_LAT = 2'd1;
  localparam logic [1:0] BANK_B_DIRECT = 2'd2;
  localparam logic [1:0] BANK_B_LAT = 2'd3;
  localparam int CMD_W = 3;
  localparam int SEL_W = 4;
  localparam int SEL_LSB = 3;
  localparam int DATA_LSB = 7;
  function automatic logic [SEL_W-1:0] bank_sel(input logic [1:0] bank);
    return 4'b0001 << bank;
  endfunction
endpackage

// File: rtl/stream_out_reg.sv
// stream_out_reg: single-entry val/rdy pipeline register; accepts a new entry whenever the slot drains
module stream_out_reg #(
  parameter int WIDTH = 23
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_msg,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_msg
);
  logic             val_q, val_d;
  logic [WIDTH-1:0] msg_q, msg_d;
  always_comb begin
    in_rdy = !val_q || out_rdy;
    val_d = (in_val && in_rdy) || (val_q && !out_rdy);
    msg_d = (in_val && in_rdy) ? in_msg : msg_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      val_q <= 1'b0;
      msg_q <= '0;
    end else begin
      val_q <= val_d;
      msg_q <= msg_d;
    end
  end
  assign out_val = val_q;
  assign out_msg = msg_q;
endmodule

// File: rtl/systolic_stream_driver.sv
// systolic_stream_driver: sequences one accelerator job IDLE->LOAD->RUN->DRAIN over val/rdy streams
module systolic_stream_driver
  import systolic_stream_driver_pkg::*;
#(
  parameter int INT_WIDTH    = 8,
  parameter int FRAC_WIDTH   = 8,
  parameter int RESULT_PAIRS = 8,
  localparam int W = INT_WIDTH + FRAC_WIDTH
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           go_val,
  output logic           go_rdy,
  input  logic           op_val,
  output logic           op_rdy,
  input  logic [W+2:0]   op_msg,
  output logic           acc_send_val,
  input  logic           acc_send_rdy,
  output logic [W+6:0]   acc_send_msg,
  input  logic           acc_recv_val,
  output logic           acc_recv_rdy,
  input  logic [2*W-1:0] acc_recv_msg,
  output logic           res_val,
  input  logic           res_rdy,
  output logic [2*W-1:0] res_msg,
  output logic           busy,
  output logic           done
);
  localparam int CW = $clog2(RESULT_PAIRS + 1);
  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic            done_q, done_d;
  logic            slot_free, pkt_val;
  logic [W+6:0]    pkt_msg;
  logic [W-1:0]    op_data;
  logic [1:0]      op_bank;
  logic            op_last;
  assign op_data = op_msg[W+2:3];
  assign op_bank = op_msg[2:1];
  assign op_last = op_msg[0];
  stream_out_reg #(.WIDTH(W + 7)) u_out (
    .clk     (clk),
    .reset   (reset),
    .in_val  (pkt_val),
    .in_rdy  (slot_free),
    .in_msg  (pkt_msg),
    .out_val (acc_send_val),
    .out_rdy (acc_send_rdy),
    .out_msg (acc_send_msg)
  );
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d = 1'b0;
    pkt_val = 1'b0;
    pkt_msg = '0;
    go_rdy = state_q == STATE_IDLE;
    busy = state_q != STATE_IDLE;
    op_rdy = state_q == STATE_LOAD && slot_free;
    // Drain is a zero-latency pass-through: the host's ready is the accelerator's ready
    res_val = state_q == STATE_DRAIN && acc_recv_val;
    acc_recv_rdy = state_q == STATE_DRAIN && res_rdy;
    res_msg = acc_recv_msg;
    case (state_q)
      STATE_IDLE: state_d = go_val ? STATE_LOAD : STATE_IDLE;
      STATE_LOAD: if (op_val && slot_free) begin
        pkt_val = 1'b1;
        pkt_msg[DATA_LSB +: W] = op_data;
        pkt_msg[SEL_LSB +: SEL_W] = bank_sel(op_bank);
        pkt_msg[CMD_W-1:0] = CMD_LOAD | (3'(op_last) << CMD_LAST);
        state_d = op_last ? STATE_RUN : STATE_LOAD;
      end
      STATE_RUN: if (slot_free) begin
        pkt_val = 1'b1;
        pkt_msg[CMD_W-1:0] = CMD_RUN;
        count_d = CW'(RESULT_PAIRS);
        state_d = STATE_DRAIN;
      end
      STATE_DRAIN: if (acc_recv_val && res_rdy) begin
        count_d = count_q - CW'(1);
        done_d = count_q == CW'(1);
        state_d = count_q == CW'(1) ? STATE_IDLE : STATE_DRAIN;
      end
      default: state_d = STATE_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= STATE_IDLE;
      count_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q <= done_d;
    end
  end
  assign done = done_q;
endmodule

// File: tb/tb_systolic_stream_driver.sv
// tb_systolic_stream_driver: table-driven and randomized checks against a packet/result queue model
module tb_systolic_stream_driver;
  localparam int W = 16;
  localparam int RP = 4;
  logic clk = 1'b0, reset = 1'b1, go_val = 1'b0, op_val = 1'b0;
  logic acc_send_rdy = 1'b0, acc_recv_val = 1'b0, res_rdy = 1'b0;
  logic [W+2:0] op_msg = '0;
  logic [2*W-1:0] acc_recv_msg = '0;
  logic go_rdy, op_rdy, acc_send_val, acc_recv_rdy, res_val, busy, done;
  logic [W+6:0] acc_send_msg;
  logic [2*W-1:0] res_msg;

  systolic_stream_driver #(.INT_WIDTH(8), .FRAC_WIDTH(8), .RESULT_PAIRS(RP)) dut (
    .clk(clk), .reset(reset), .go_val(go_val), .go_rdy(go_rdy),
    .op_val(op_val), .op_rdy(op_rdy), .op_msg(op_msg),
    .acc_send_val(acc_send_val), .acc_send_rdy(acc_send_rdy), .acc_send_msg(acc_send_msg),
    .acc_recv_val(acc_recv_val), .acc_recv_rdy(acc_recv_rdy), .acc_recv_msg(acc_recv_msg),
    .res_val(res_val), .res_rdy(res_rdy), .res_msg(res_msg), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic [1:0]   bank;
    logic         last;
    logic [W+6:0] pkt;
  } vec_t;
  vec_t tbl[4];

  int checks = 0, errors = 0, send_mode = 0, res_mode = 0, accel_pending = 0;
  int done_cnt = 0, job_fires = 0, jobs_done = 0;
  bit recv_fired = 0, exp_done_now = 0;
  logic [W+6:0] exp_pkt[$];
  logic [2*W-1:0] exp_res[$], accel_data[$];
  localparam logic [W+6:0] RUN_PKT = 23'h000001;

  function automatic logic [W+6:0] pack(input logic [W-1:0] d, input logic [1:0] b, input logic l);
    logic [3:0] sel;
    sel = 4'(1 << b);
    return {d, sel, 1'b1, l, 1'b0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Observes every transfer at the falling edge, where both sides are stable
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_pkt.delete();
        job_fires = 0;
        exp_done_now = 0;
        recv_fired = 0;
      end else begin
        if (done || exp_done_now) check("done_pulse", 32'(done), 32'(exp_done_now));
        if (done) done_cnt++;
        exp_done_now = 0;
        if (acc_send_val && acc_send_rdy) begin
          if (exp_pkt.size() > 0) check("packet", 32'(acc_send_msg), 32'(exp_pkt.pop_front()));
          else flag_fail("packet_unexpected");
        end
        if (res_val && res_rdy) begin
          if (exp_res.size() > 0) check("result", res_msg, exp_res.pop_front());
          else flag_fail("result_unexpected");
          job_fires++;
          if (job_fires == RP) begin
            job_fires = 0;
            exp_done_now = 1;
          end
        end
        if (acc_recv_val && acc_recv_rdy) recv_fired = 1;
      end
    end
  endtask

  // Accelerator and host ready model
  task automatic drivers();
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        acc_recv_val = 1'b0;
        accel_pending = 0;
        exp_res.delete();
        accel_data.delete();
        recv_fired = 0;
      end else begin
        if (recv_fired) begin
          acc_recv_val = 1'b0;
          recv_fired = 0;
        end
        if (!acc_recv_val && accel_pending > 0) begin
          if (accel_data.size() > 0) acc_recv_msg = accel_data.pop_front();
          else acc_recv_msg = $urandom;
          acc_recv_val = 1'b1;
          accel_pending--;
          exp_res.push_back(acc_recv_msg);
        end
      end
      acc_send_rdy = send_mode == 0 ? 1'b1 : send_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
      res_rdy = res_mode == 0 ? 1'b1 : res_mode == 1 ? 1'($urandom_range(0, 1)) : !res_rdy;
    end
  endtask

  task automatic start_job(input bit keep);
    int t;
    @(posedge clk);
    #1;
    accel_pending += RP;
    go_val = 1'b1;
    for (t = 0; t < 100; t++) begin
      @(negedge clk);
      if (go_rdy) break;
    end
    if (t == 100) flag_fail("go_timeout");
    @(posedge clk);
    #1;
    go_val = keep;
  endtask

  task automatic send_op(input logic [W-1:0] d, input logic [1:0] b, input logic l, input logic [W+6:0] exp);
    int t;
    @(posedge clk);
    #1;
    op_msg = {d, b, l};
    op_val = 1'b1;
    for (t = 0; t < 200; t++) begin
      @(negedge clk);
      if (op_rdy) break;
    end
    if (t == 200) flag_fail("op_timeout");
    @(posedge clk);
    #1;
    op_val = 1'b0;
    exp_pkt.push_back(exp);
    if (l) exp_pkt.push_back(RUN_PKT);
  endtask

  task automatic wait_done(input bit drain);
    int t;
    for (t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (done) break;
    end
    if (t == 1000) flag_fail("done_timeout");
    jobs_done++;
    if (drain) begin
      for (t = 0; t < 100 && exp_pkt.size() > 0; t++) @(negedge clk);
      check("packets_drained", 32'(exp_pkt.size()), 0);
    end
  endtask

  initial begin
    int d0, n;
    logic [W-1:0] d;
    logic [1:0] b;
    tbl[0] = '{16'h0102, 2'd0, 1'b0, 23'h00810C};
    tbl[1] = '{16'h0304, 2'd3, 1'b1, 23'h018246};
    tbl[2] = '{16'hBEEF, 2'd1, 1'b0, 23'h5F7794};
    tbl[3] = '{16'h1234, 2'd2, 1'b1, 23'h091A26};
    fork
      monitor();
      drivers();
    join_none
    @(negedge clk);
    check("rst_go_rdy", 32'(go_rdy), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_send_val", 32'(acc_send_val), 0);
    check("rst_send_msg", 32'(acc_send_msg), 0);
    check("rst_done", 32'(done), 0);
    check("rst_op_rdy", 32'(op_rdy), 0);
    check("rst_recv_rdy", 32'(acc_recv_rdy), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Table-driven jobs: reference example, then a second vector pair under random backpressure
    start_job(0);
    for (int i = 0; i < 2; i++) send_op(tbl[i].data, tbl[i].bank, tbl[i].last, tbl[i].pkt);
    wait_done(1);
    send_mode = 1;
    res_mode = 1;
    start_job(0);
    for (int i = 2; i < 4; i++) send_op(tbl[i].data, tbl[i].bank, tbl[i].last, tbl[i].pkt);
    wait_done(1);

    // Output register stalled: message holds, no operand taken
    send_mode = 2;
    res_mode = 0;
    start_job(0);
    send_op(tbl[0].data, tbl[0].bank, tbl[0].last, tbl[0].pkt);
    op_msg = {tbl[1].data, tbl[1].bank, tbl[1].last};
    op_val = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_op_rdy", 32'(op_rdy), 0);
      check("stall_send_val", 32'(acc_send_val), 1);
      check("stall_send_msg", 32'(acc_send_msg), 32'(tbl[0].pkt));
    end
    send_mode = 0;
    send_op(tbl[1].data, tbl[1].bank, tbl[1].last, tbl[1].pkt);
    wait_done(1);

    // Results offered during LOAD are refused; toggling host ready during drain
    res_mode = 2;
    accel_data.push_back(32'hAAAA5555);
    accel_data.push_back(32'h5555AAAA);
    accel_data.push_back(32'hAAAA0001);
    accel_data.push_back(32'h0002AAAA);
    d0 = done_cnt;
    start_job(0);
    repeat (2) begin
      @(negedge clk);
      check("load_recv_val_bench", 32'(acc_recv_val), 1);
      check("load_recv_rdy", 32'(acc_recv_rdy), 0);
      check("load_res_val", 32'(res_val), 0);
    end
    send_op(tbl[2].data, tbl[2].bank, tbl[2].last, tbl[2].pkt);
    @(negedge clk);
    check("load_recv_rdy2", 32'(acc_recv_rdy), 0);
    check("load_res_val2", 32'(res_val), 0);
    send_op(tbl[3].data, tbl[3].bank, tbl[3].last, tbl[3].pkt);
    wait_done(1);
    repeat (5) @(negedge clk);
    check("done_once", 32'(done_cnt - d0), 1);
    check("after_done_busy", 32'(busy), 0);
    check("after_done_go_rdy", 32'(go_rdy), 1);
    res_mode = 0;

    // Reset in the middle of LOAD after two operands
    start_job(0);
    send_op(tbl[0].data, tbl[0].bank, tbl[0].last, tbl[0].pkt);
    send_op(tbl[2].data, tbl[2].bank, tbl[2].last, tbl[2].pkt);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_send_val", 32'(acc_send_val), 0);
    check("midrst_go_rdy", 32'(go_rdy), 1);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("postrst_busy", 32'(busy), 0);
      check("postrst_send_val", 32'(acc_send_val), 0);
    end
    start_job(0);
    for (int i = 0; i < 2; i++) send_op(tbl[i].data, tbl[i].bank, tbl[i].last, tbl[i].pkt);
    wait_done(1);

    // go held high across a whole job: exactly one IDLE cycle, then an identical job
    start_job(1);
    for (int i = 0; i < 2; i++) send_op(tbl[i].data, tbl[i].bank, tbl[i].last, tbl[i].pkt);
    wait_done(0);
    check("gap_idle_go_rdy", 32'(go_rdy), 1);
    accel_pending += RP;
    @(negedge clk);
    check("gap_reload_go_rdy", 32'(go_rdy), 0);
    check("gap_reload_busy", 32'(busy), 1);
    go_val = 1'b0;
    for (int i = 0; i < 2; i++) send_op(tbl[i].data, tbl[i].bank, tbl[i].last, tbl[i].pkt);
    wait_done(1);

    // Randomized jobs against the packing model
    send_mode = 1;
    res_mode = 1;
    for (int j = 0; j < 25; j++) begin
      n = $urandom_range(1, 5);
      start_job(0);
      for (int i = 0; i < n; i++) begin
        d = W'($urandom);
        b = 2'($urandom_range(0, 3));
        send_op(d, b, i == n - 1, pack(d, b, i == n - 1));
      end
      wait_done(1);
    end
    repeat (3) @(negedge clk);
    check("results_drained", 32'(exp_res.size()), 0);
    check("done_total", 32'(done_cnt), 32'(jobs_done));
    check("final_busy", 32'(busy), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
